// File: rtl/spi_txn_sequencer.sv
// Host request front end for top_module_spi: queues read/write requests, formats
// the 40-bit WDATA word, sequences start/done handshakes and packs read bytes.
module spi_txn_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [6:0]  req_addr,
    input  logic [1:0]  req_len,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  cfg_mode,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic [39:0] spi_wdata,
    output logic [1:0]  spi_mode,
    output logic        spi_start,
    input  logic [7:0]  spi_rdata,
    input  logic        spi_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_NEXT   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    typedef struct packed {
        logic        write;
        logic [6:0]  addr;
        logic [1:0]  len;
        logic [31:0] wdata;
    } req_t;

    req_t          fifo_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          fifo_empty, fifo_full, push, pop;
    req_t          head;

    logic [2:0]    state_q, state_d;
    req_t          cur_q, cur_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          done_q, done_edge;
    logic [39:0]   wdata_q, wdata_d;
    logic [1:0]    mode_q, mode_d;

    // Extra pointer MSB distinguishes full from empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = req_valid && !fifo_full;
    assign pop        = (state_q == S_IDLE) && !fifo_empty;
    assign head       = fifo_q[rd_ptr_q[AW-1:0]];
    assign done_edge  = spi_done && !done_q;

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q[AW-1:0]] <= '{req_write, req_addr, req_len, req_wdata};
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    cur_d   = head;
                    cnt_d   = 2'd0;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    // Launch word is registered on entry so it is valid during LAUNCH.
                    wdata_d = {head.write, head.addr, head.write ? head.wdata : 32'h0};
                    mode_d  = cfg_mode;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (done_edge) begin
                    if (!cur_q.write) rdata_d[8*cnt_q +: 8] = spi_rdata;
                    state_d = (!cur_q.write && cnt_q < cur_q.len) ? S_NEXT : S_RESP;
                end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_NEXT: begin
                cnt_d   = cnt_q + 2'd1;
                wdata_d = {1'b0, cur_q.addr + {5'b0, 2'(cnt_q + 2'd1)}, 32'h0};
                mode_d  = cfg_mode;
                state_d = S_LAUNCH;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= S_IDLE;
            cur_q    <= '0;
            cnt_q    <= 2'd0;
            timer_q  <= '0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            wdata_q  <= 40'h0;
            mode_q   <= 2'b00;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            done_q  <= spi_done;
            wdata_q <= wdata_d;
            mode_q  <= mode_d;
        end
    end

    assign req_ready  = !fifo_full;
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_valid ? rdata_q : 32'h0;
    assign resp_err   = resp_valid && err_q;
    assign busy       = (state_q != S_IDLE) || !fifo_empty;
    assign spi_wdata  = wdata_q;
    assign spi_mode   = mode_q;
    assign spi_start  = (state_q == S_LAUNCH);
endmodule
